nn_weight_fetch: RTL and testbench

Per-lane weight-memory read engine that sits between the layer sequencer and the MAC lanes of the fully-connected accelerator. It consumes the sequencer's per-lane `rd_en` strobes and its `base_addr` / `start_offset` / `stride` / `layer_no` / `feed_through` controls. From these it generates sequential read addresses for one weight bank per lane, tracks the bank's fixed read latency, and returns weight words to each MAC lane with aligned `w_valid` and `w_first` flags.

---
 rtl/nn_weight_fetch.sv | 153 +++++++++++++++
 tb/tb_nn_weight_fetch.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_weight_fetch.sv
// nn_weight_fetch: per-lane weight-bank read engine.
// Turns the sequencer's per-lane rd_en bursts into sequential bank reads,
// follows the fixed bank latency with a tag pipeline, and returns the words
// to each MAC lane with aligned w_valid / w_first.
//
// Flow control: there is no backpressure anywhere. rd_en[l] is a level; every
// edge it is sampled high while the lane runs issues exactly one read, and
// every issued read comes back as exactly one w_valid cycle MEM_LAT+1 edges
// after the rd_en sample, unless feed_through drops it first. The MAC lane
// must accept w_data on every cycle w_valid is high.
module nn_weight_fetch #(
  parameter int LANES   = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LANES-1:0]        rd_en,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [ADDR_W-1:0]       start_offset,
  input  logic [ADDR_W-1:0]       stride,
  input  logic [2:0]              layer_no,
  input  logic                    feed_through,
  output logic [LANES-1:0]        mem_rd,
  output logic [LANES*ADDR_W-1:0] mem_addr,
  input  logic [LANES*DATA_W-1:0] mem_rdata,
  output logic [LANES*DATA_W-1:0] w_data,
  output logic [LANES-1:0]        w_valid,
  output logic [LANES-1:0]        w_first,
  output logic [LANES*11-1:0]     fetch_cnt,
  output logic                    busy,
  output logic [2:0]              cur_layer,
  output logic [LANES-1:0]        lane_run   // debug: lane FSM state, 1 = RUN
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} lane_state_t;

  localparam logic [10:0] CNT_MAX = 11'd2047;

  logic [LANES-1:0] start_vec;
  logic [LANES-1:0] lane_busy;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    lane_state_t        state;
    logic               rd_en_q;
    logic               rd_r;
    logic               first_r;
    logic               wv_r;
    logic               wf_r;
    logic [ADDR_W-1:0]  base_r;
    logic [ADDR_W-1:0]  k_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [ADDR_W-1:0]  base_new;
    logic [DATA_W-1:0]  wd_r;
    logic [10:0]        cnt_r;
    logic [MEM_LAT-1:0] tag_v;
    logic [MEM_LAT-1:0] tag_f;

    // Lane base address; wraps naturally at ADDR_W bits.
    assign base_new     = base_addr + start_offset + ADDR_W'(l) * stride;
    // A burst starts on an rd_en rising edge seen while idle; flush wins.
    assign start_vec[l] = !feed_through && (state == ST_IDLE) && rd_en[l] && !rd_en_q;

    // Lane FSM, address generation, tag pipeline and data return.
    // The tag pipeline is fed from the registered mem_rd, so a tag leaves
    // it in the same cycle the bank drives the matching mem_rdata.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state   <= ST_IDLE;
        rd_en_q <= 1'b0;
        rd_r    <= 1'b0;
        first_r <= 1'b0;
        base_r  <= '0;
        k_r     <= '0;
        addr_r  <= '0;
        cnt_r   <= '0;
        tag_v   <= '0;
        tag_f   <= '0;
        wv_r    <= 1'b0;
        wf_r    <= 1'b0;
        wd_r    <= '0;
      end else begin
        rd_en_q <= rd_en[l];
        if (feed_through) begin
          state   <= ST_IDLE;
          rd_r    <= 1'b0;
          first_r <= 1'b0;
          tag_v   <= '0;
          tag_f   <= '0;
          wv_r    <= 1'b0;
          wf_r    <= 1'b0;
        end else begin
          tag_v[0] <= rd_r;
          tag_f[0] <= first_r;
          for (int i = 1; i < MEM_LAT; i++) begin
            tag_v[i] <= tag_v[i-1];
            tag_f[i] <= tag_f[i-1];
          end
          wv_r <= tag_v[MEM_LAT-1];
          wf_r <= tag_f[MEM_LAT-1];
          if (tag_v[MEM_LAT-1]) begin
            wd_r <= mem_rdata[l*DATA_W +: DATA_W];
          end

          if (start_vec[l]) begin
            // First read of the burst goes out on the start edge itself.
            state   <= ST_RUN;
            base_r  <= base_new;
            addr_r  <= base_new;
            k_r     <= {{(ADDR_W-1){1'b0}}, 1'b1};
            cnt_r   <= 11'd1;
            rd_r    <= 1'b1;
            first_r <= 1'b1;
          end else if ((state == ST_RUN) && rd_en[l]) begin
            addr_r  <= base_r + k_r;
            k_r     <= k_r + 1'b1;
            rd_r    <= 1'b1;
            first_r <= 1'b0;
            if (cnt_r != CNT_MAX) begin
              cnt_r <= cnt_r + 11'd1;
            end
          end else begin
            state   <= ST_IDLE;
            rd_r    <= 1'b0;
            first_r <= 1'b0;
          end
        end
      end
    end

    assign mem_rd[l]                       = rd_r;
    assign mem_addr[l*ADDR_W +: ADDR_W]    = addr_r;
    assign w_data[l*DATA_W +: DATA_W]      = wd_r;
    assign w_valid[l]                      = wv_r;
    assign w_first[l]                      = wf_r;
    assign fetch_cnt[l*11 +: 11]           = cnt_r;
    assign lane_run[l]                     = (state == ST_RUN);
    assign lane_busy[l]                    = (state == ST_RUN) | rd_r | (|tag_v) | wv_r;
  end

  assign busy = |lane_busy;

  // Remember which layer the most recent burst belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_layer <= 3'd0;
    end else if (|start_vec) begin
      cur_layer <= layer_no;
    end
  end

endmodule

// File: tb/tb_nn_weight_fetch.sv
// Directed testbench for nn_weight_fetch: one MEM_LAT=2 instance and one
// MEM_LAT=3 instance share the stimulus; a bank model per instance returns
// a recognisable word for each address after the right latency.
module tb_nn_weight_fetch;

  logic        clk;
  logic        rst_n;
  logic [3:0]  rd_en;
  logic [9:0]  base_addr;
  logic [9:0]  start_offset;
  logic [9:0]  stride;
  logic [2:0]  layer_no;
  logic        feed_through;

  logic [3:0]  mem_rd, w_valid, w_first, lane_run;
  logic [39:0] mem_addr;
  logic [63:0] mem_rdata, w_data;
  logic [43:0] fetch_cnt;
  logic        busy;
  logic [2:0]  cur_layer;

  logic [3:0]  mem_rd_3, w_valid_3, w_first_3, lane_run_3;
  logic [39:0] mem_addr_3;
  logic [63:0] mem_rdata_3, w_data_3;
  logic [43:0] fetch_cnt_3;
  logic        busy_3;
  logic [2:0]  cur_layer_3;

  int vec_cnt = 0;
  int err_cnt = 0;

  nn_weight_fetch #(.LANES(4), .ADDR_W(10), .DATA_W(16), .MEM_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .base_addr(base_addr),
    .start_offset(start_offset), .stride(stride), .layer_no(layer_no),
    .feed_through(feed_through), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .w_data(w_data), .w_valid(w_valid),
    .w_first(w_first), .fetch_cnt(fetch_cnt), .busy(busy),
    .cur_layer(cur_layer), .lane_run(lane_run)
  );

  nn_weight_fetch #(.LANES(4), .ADDR_W(10), .DATA_W(16), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .base_addr(base_addr),
    .start_offset(start_offset), .stride(stride), .layer_no(layer_no),
    .feed_through(feed_through), .mem_rd(mem_rd_3), .mem_addr(mem_addr_3),
    .mem_rdata(mem_rdata_3), .w_data(w_data_3), .w_valid(w_valid_3),
    .w_first(w_first_3), .fetch_cnt(fetch_cnt_3), .busy(busy_3),
    .cur_layer(cur_layer_3), .lane_run(lane_run_3)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vec_cnt);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [15:0] word(input int l, input logic [9:0] a);
    logic [1:0] ln;
    ln = l[1:0];
    return {ln, 4'hC, a};
  endfunction

  function automatic logic [9:0] addr_at(input logic [39:0] v, input int l);
    return v[l*10 +: 10];
  endfunction

  function automatic logic [15:0] data_at(input logic [63:0] v, input int l);
    return v[l*16 +: 16];
  endfunction

  function automatic logic [10:0] cnt_at(input logic [43:0] v, input int l);
    return v[l*11 +: 11];
  endfunction

  // ---------------- bank models ----------------
  // Sampled each negedge; data for a read seen in cycle c is driven in cycle c+LAT.
  logic       hv2 [4][8];
  logic [9:0] ha2 [4][8];
  logic       hv3 [4][8];
  logic [9:0] ha3 [4][8];

  initial begin
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 8; i++) begin
        hv2[l][i] = 1'b0; ha2[l][i] = '0;
        hv3[l][i] = 1'b0; ha3[l][i] = '0;
      end
    end
    mem_rdata   = '0;
    mem_rdata_3 = '0;
  end

  always @(negedge clk) begin
    for (int l = 0; l < 4; l++) begin
      for (int i = 7; i > 0; i--) begin
        hv2[l][i] = hv2[l][i-1]; ha2[l][i] = ha2[l][i-1];
        hv3[l][i] = hv3[l][i-1]; ha3[l][i] = ha3[l][i-1];
      end
      hv2[l][0] = mem_rd[l];   ha2[l][0] = addr_at(mem_addr, l);
      hv3[l][0] = mem_rd_3[l]; ha3[l][0] = addr_at(mem_addr_3, l);
      mem_rdata[l*16 +: 16]   = hv2[l][2] ? word(l, ha2[l][2]) : 16'hDEAD;
      mem_rdata_3[l*16 +: 16] = hv3[l][3] ? word(l, ha3[l][3]) : 16'hDEAD;
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b1; rd_en = '0; base_addr = '0; start_offset = '0; stride = '0;
    layer_no = '0; feed_through = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vec_cnt++; if (mem_rd !== 4'h0 || mem_rd_3 !== 4'h0) begin err_cnt++;
      $display("FAIL reset_mem_rd: got %h/%h want 0", mem_rd, mem_rd_3); end
    vec_cnt++; if (mem_addr !== 40'h0 || w_data !== 64'h0) begin err_cnt++;
      $display("FAIL reset_addr_data: got %h/%h want 0", mem_addr, w_data); end
    vec_cnt++; if (w_valid !== 4'h0 || w_first !== 4'h0) begin err_cnt++;
      $display("FAIL reset_w_flags: got %h/%h want 0", w_valid, w_first); end
    vec_cnt++; if (fetch_cnt !== 44'h0 || busy !== 1'b0 || cur_layer !== 3'd0) begin err_cnt++;
      $display("FAIL reset_status: cnt=%h busy=%b layer=%0d want 0", fetch_cnt, busy, cur_layer); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vec_cnt++; if (mem_rd !== 4'h0 || busy !== 1'b0 || lane_run !== 4'h0) begin err_cnt++;
      $display("FAIL reset_release_idle: mem_rd=%h busy=%b run=%h want 0", mem_rd, busy, lane_run); end
  endtask

  task automatic test_basic();
    logic e_rd, e_wv;
    logic [9:0] ea;
    logic [15:0] ed;
    base_addr = 10'd100; start_offset = 10'd5; stride = 10'd20; layer_no = 3'd3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      e_rd = (i >= 1 && i <= 4);
      e_wv = (i >= 4 && i <= 7);
      for (int l = 0; l < 4; l++) begin
        vec_cnt++; if (mem_rd[l] !== e_rd) begin err_cnt++;
          $display("FAIL basic_mem_rd i=%0d lane=%0d: got %b want %b", i, l, mem_rd[l], e_rd); end
        if (e_rd) begin
          ea = 10'(105 + 20*l + i - 1);
          vec_cnt++; if (addr_at(mem_addr, l) !== ea) begin err_cnt++;
            $display("FAIL basic_addr i=%0d lane=%0d: got %0d want %0d", i, l, addr_at(mem_addr, l), ea); end
        end
        vec_cnt++; if (w_valid[l] !== e_wv || w_first[l] !== (i == 4)) begin err_cnt++;
          $display("FAIL basic_w_flags i=%0d lane=%0d: got v=%b f=%b want v=%b f=%b", i, l, w_valid[l], w_first[l], e_wv, (i == 4)); end
        if (e_wv) begin
          ed = word(l, 10'(105 + 20*l + i - 4));
          vec_cnt++; if (data_at(w_data, l) !== ed) begin err_cnt++;
            $display("FAIL basic_w_data i=%0d lane=%0d: got %h want %h", i, l, data_at(w_data, l), ed); end
        end
      end
      vec_cnt++; if (busy !== (i >= 1 && i <= 7)) begin err_cnt++;
        $display("FAIL basic_busy i=%0d: got %b want %b", i, busy, (i >= 1 && i <= 7)); end
      rd_en = (i < 4) ? 4'hF : 4'h0;
    end
    for (int l = 0; l < 4; l++) begin
      vec_cnt++; if (cnt_at(fetch_cnt, l) !== 11'd4) begin err_cnt++;
        $display("FAIL basic_fetch_cnt lane=%0d: got %0d want 4", l, cnt_at(fetch_cnt, l)); end
    end
    vec_cnt++; if (cur_layer !== 3'd3) begin err_cnt++;
      $display("FAIL basic_cur_layer: got %0d want 3", cur_layer); end
  endtask

  task automatic test_wrap();
    logic [9:0] wa [6];
    logic e_rd, e_wv;
    wa[0] = 10'd1020; wa[1] = 10'd1021; wa[2] = 10'd1022;
    wa[3] = 10'd1023; wa[4] = 10'd0;    wa[5] = 10'd1;
    base_addr = 10'd1020; start_offset = 10'd0; stride = 10'd0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      e_rd = (i >= 1 && i <= 6);
      e_wv = (i >= 4 && i <= 9);
      vec_cnt++; if (mem_rd !== {3'b000, e_rd}) begin err_cnt++;
        $display("FAIL wrap_mem_rd i=%0d: got %b want %b", i, mem_rd, {3'b000, e_rd}); end
      if (e_rd) begin
        vec_cnt++; if (addr_at(mem_addr, 0) !== wa[i-1]) begin err_cnt++;
          $display("FAIL wrap_addr i=%0d: got %0d want %0d", i, addr_at(mem_addr, 0), wa[i-1]); end
      end
      vec_cnt++; if (w_valid !== {3'b000, e_wv} || w_first !== {3'b000, (i == 4)}) begin err_cnt++;
        $display("FAIL wrap_w_flags i=%0d: got v=%b f=%b", i, w_valid, w_first); end
      if (e_wv) begin
        vec_cnt++; if (data_at(w_data, 0) !== word(0, wa[i-4])) begin err_cnt++;
          $display("FAIL wrap_w_data i=%0d: got %h want %h", i, data_at(w_data, 0), word(0, wa[i-4])); end
      end
      rd_en = (i < 6) ? 4'h1 : 4'h0;
    end
    vec_cnt++; if (cnt_at(fetch_cnt, 0) !== 11'd6) begin err_cnt++;
      $display("FAIL wrap_fetch_cnt: got %0d want 6", cnt_at(fetch_cnt, 0)); end
    vec_cnt++; if (cnt_at(fetch_cnt, 3) !== 11'd4) begin err_cnt++;
      $display("FAIL wrap_fetch_cnt_hold lane3: got %0d want 4", cnt_at(fetch_cnt, 3)); end
  endtask

  task automatic test_independent_lanes();
    logic [3:0] e_rd, e_wv, e_wf;
    int n0, n1;
    n0 = 0; n1 = 0;
    base_addr = 10'd200; start_offset = 10'd0; stride = 10'd10; layer_no = 3'd1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      e_rd = {2'b00, (i >= 4 && i <= 5), (i >= 1 && i <= 3)};
      e_wv = {2'b00, (i >= 7 && i <= 8), (i >= 4 && i <= 6)};
      e_wf = {2'b00, (i == 7), (i == 4)};
      if (mem_rd[0] === 1'b1) n0++;
      if (mem_rd[1] === 1'b1) n1++;
      vec_cnt++; if (mem_rd !== e_rd) begin err_cnt++;
        $display("FAIL indep_mem_rd i=%0d: got %b want %b", i, mem_rd, e_rd); end
      vec_cnt++; if (w_valid !== e_wv || w_first !== e_wf) begin err_cnt++;
        $display("FAIL indep_w_flags i=%0d: got v=%b f=%b want v=%b f=%b", i, w_valid, w_first, e_wv, e_wf); end
      if (e_rd[0]) begin
        vec_cnt++; if (addr_at(mem_addr, 0) !== 10'(200 + i - 1)) begin err_cnt++;
          $display("FAIL indep_addr0 i=%0d: got %0d want %0d", i, addr_at(mem_addr, 0), 200 + i - 1); end
      end
      if (e_rd[1]) begin
        vec_cnt++; if (addr_at(mem_addr, 1) !== 10'(210 + i - 4)) begin err_cnt++;
          $display("FAIL indep_addr1 i=%0d: got %0d want %0d", i, addr_at(mem_addr, 1), 210 + i - 4); end
      end
      if (e_wv[1]) begin
        vec_cnt++; if (data_at(w_data, 1) !== word(1, 10'(210 + i - 7))) begin err_cnt++;
          $display("FAIL indep_w_data1 i=%0d: got %h want %h", i, data_at(w_data, 1), word(1, 10'(210 + i - 7))); end
      end
      rd_en = (i < 3) ? 4'h1 : ((i < 5) ? 4'h2 : 4'h0);
    end
    vec_cnt++; if (n0 != 3 || n1 != 2) begin err_cnt++;
      $display("FAIL indep_read_count: got %0d/%0d want 3/2", n0, n1); end
    vec_cnt++; if (cnt_at(fetch_cnt, 0) !== 11'd3 || cnt_at(fetch_cnt, 1) !== 11'd2) begin err_cnt++;
      $display("FAIL indep_fetch_cnt: got %0d/%0d want 3/2", cnt_at(fetch_cnt, 0), cnt_at(fetch_cnt, 1)); end
    vec_cnt++; if (cnt_at(fetch_cnt, 2) !== 11'd4) begin err_cnt++;
      $display("FAIL indep_fetch_cnt_hold lane2: got %0d want 4", cnt_at(fetch_cnt, 2)); end
    vec_cnt++; if (cur_layer !== 3'd1) begin err_cnt++;
      $display("FAIL indep_cur_layer: got %0d want 1", cur_layer); end
  endtask

  task automatic test_flush();
    base_addr = 10'd300; start_offset = 10'd0; stride = 10'd1; layer_no = 3'd5;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      vec_cnt++; if (mem_rd_3 !== ((i == 1) ? 4'hF : 4'h0) || mem_rd !== ((i == 1) ? 4'hF : 4'h0)) begin err_cnt++;
        $display("FAIL flush_mem_rd i=%0d: got %b/%b", i, mem_rd, mem_rd_3); end
      if (i == 1) begin
        vec_cnt++; if (addr_at(mem_addr_3, 3) !== 10'd303) begin err_cnt++;
          $display("FAIL flush_addr lane3: got %0d want 303", addr_at(mem_addr_3, 3)); end
      end
      vec_cnt++; if (w_valid_3 !== 4'h0 || w_valid !== 4'h0) begin err_cnt++;
        $display("FAIL flush_w_valid i=%0d: got %b/%b want 0", i, w_valid, w_valid_3); end
      if (i != 2) begin
        vec_cnt++; if (busy_3 !== (i == 1)) begin err_cnt++;
          $display("FAIL flush_busy i=%0d: got %b want %b", i, busy_3, (i == 1)); end
      end
      rd_en = (i < 4) ? 4'hF : 4'h0;
      feed_through = (i == 1);
    end
    for (int l = 0; l < 4; l++) begin
      vec_cnt++; if (cnt_at(fetch_cnt_3, l) !== 11'd1) begin err_cnt++;
        $display("FAIL flush_fetch_cnt lane=%0d: got %0d want 1", l, cnt_at(fetch_cnt_3, l)); end
    end
    vec_cnt++; if (cur_layer_3 !== 3'd5) begin err_cnt++;
      $display("FAIL flush_cur_layer: got %0d want 5", cur_layer_3); end
  endtask

  task automatic test_retrigger();
    logic e_rd, e_wv, e_wf;
    logic [9:0] ea, da;
    int nf;
    nf = 0;
    base_addr = 10'd0; start_offset = 10'd0; stride = 10'd0; layer_no = 3'd2;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      e_rd = (i == 1 || i == 2 || i == 4 || i == 5);
      e_wv = (i == 4 || i == 5 || i == 7 || i == 8);
      e_wf = (i == 4 || i == 7);
      ea = (i <= 2) ? 10'(i - 1) : 10'(500 + i - 4);
      da = (i <= 5) ? 10'(i - 4) : 10'(500 + i - 7);
      if (w_first[0] === 1'b1) nf++;
      vec_cnt++; if (mem_rd !== {3'b000, e_rd}) begin err_cnt++;
        $display("FAIL retrig_mem_rd i=%0d: got %b want %b", i, mem_rd, {3'b000, e_rd}); end
      if (e_rd) begin
        vec_cnt++; if (addr_at(mem_addr, 0) !== ea) begin err_cnt++;
          $display("FAIL retrig_addr i=%0d: got %0d want %0d", i, addr_at(mem_addr, 0), ea); end
      end
      vec_cnt++; if (w_valid !== {3'b000, e_wv} || w_first !== {3'b000, e_wf}) begin err_cnt++;
        $display("FAIL retrig_w_flags i=%0d: got v=%b f=%b", i, w_valid, w_first); end
      if (e_wv) begin
        vec_cnt++; if (data_at(w_data, 0) !== word(0, da)) begin err_cnt++;
          $display("FAIL retrig_w_data i=%0d: got %h want %h", i, data_at(w_data, 0), word(0, da)); end
      end
      rd_en = (i == 0 || i == 1 || i == 3 || i == 4) ? 4'h1 : 4'h0;
      if (i == 2) base_addr = 10'd500;
      if (i == 4) begin start_offset = 10'd7; stride = 10'd3; end
    end
    vec_cnt++; if (nf != 2) begin err_cnt++;
      $display("FAIL retrig_first_count: got %0d want 2", nf); end
    vec_cnt++; if (cnt_at(fetch_cnt, 0) !== 11'd2) begin err_cnt++;
      $display("FAIL retrig_fetch_cnt: got %0d want 2", cnt_at(fetch_cnt, 0)); end
  endtask

  task automatic test_async_reset();
    base_addr = 10'd50; start_offset = 10'd0; stride = 10'd100; layer_no = 3'd6;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rd_en = 4'hF;
    end
    @(negedge clk);
    vec_cnt++; if (mem_rd !== 4'hF) begin err_cnt++;
      $display("FAIL areset_pre_burst: got %b want 1111", mem_rd); end
    #2;
    rst_n = 1'b0;
    rd_en = 4'h0;
    #1;
    vec_cnt++; if (mem_rd !== 4'h0 || mem_rd_3 !== 4'h0 || mem_addr !== 40'h0) begin err_cnt++;
      $display("FAIL areset_mem: rd=%b/%b addr=%h want 0", mem_rd, mem_rd_3, mem_addr); end
    vec_cnt++; if (w_data !== 64'h0 || w_valid !== 4'h0 || w_first !== 4'h0) begin err_cnt++;
      $display("FAIL areset_w: data=%h v=%b f=%b want 0", w_data, w_valid, w_first); end
    vec_cnt++; if (fetch_cnt !== 44'h0 || busy !== 1'b0 || cur_layer !== 3'd0 || busy_3 !== 1'b0) begin err_cnt++;
      $display("FAIL areset_status: cnt=%h busy=%b layer=%0d want 0", fetch_cnt, busy, cur_layer); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vec_cnt++; if (mem_rd !== 4'h0 || busy !== 1'b0 || w_valid !== 4'h0) begin err_cnt++;
        $display("FAIL areset_quiet i=%0d: rd=%b busy=%b v=%b want 0", i, mem_rd, busy, w_valid); end
    end
    for (int k = 0; k < 7; k++) begin
      if (k > 0) begin
        vec_cnt++; if (mem_rd !== ((k == 1) ? 4'h2 : 4'h0)) begin err_cnt++;
          $display("FAIL areset_restart_rd k=%0d: got %b", k, mem_rd); end
        vec_cnt++; if (w_valid !== ((k == 4) ? 4'h2 : 4'h0) || w_first !== ((k == 4) ? 4'h2 : 4'h0)) begin err_cnt++;
          $display("FAIL areset_restart_w k=%0d: got v=%b f=%b", k, w_valid, w_first); end
        vec_cnt++; if (busy !== (k >= 1 && k <= 4)) begin err_cnt++;
          $display("FAIL areset_restart_busy k=%0d: got %b", k, busy); end
      end
      if (k == 1) begin
        vec_cnt++; if (addr_at(mem_addr, 1) !== 10'd150) begin err_cnt++;
          $display("FAIL areset_restart_addr: got %0d want 150", addr_at(mem_addr, 1)); end
      end
      if (k == 4) begin
        vec_cnt++; if (data_at(w_data, 1) !== word(1, 10'd150)) begin err_cnt++;
          $display("FAIL areset_restart_data: got %h want %h", data_at(w_data, 1), word(1, 10'd150)); end
      end
      rd_en = (k == 0) ? 4'h2 : 4'h0;
      @(negedge clk);
    end
    vec_cnt++; if (cnt_at(fetch_cnt, 1) !== 11'd1 || cur_layer !== 3'd6) begin err_cnt++;
      $display("FAIL areset_restart_status: cnt=%0d layer=%0d want 1/6", cnt_at(fetch_cnt, 1), cur_layer); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_independent_lanes();
    test_flush();
    test_retrigger();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
